// File: rtl/stopwatch_time_counter_if.sv
// -----------------------------------------------------------------------------
// stopwatch_time_counter_if
//
// Bundles the control inputs and display outputs of the stopwatch time
// counter. CLK and RST are kept outside the bundle as plain module ports.
//
// Signals:
//   EN100HZ  10 ms tick from the upstream tick generator (already run-gated)
//   CLR      synchronous clear of live count, lap register and lap mode
//   LAP      single-cycle pulse toggling lap-hold mode
//   DISP     24-bit BCD display value {M10,M1,S10,S1,C10,C1}
//   LAPHOLD  high while DISP shows the frozen lap value
//   OVF      one-cycle pulse on the tick arriving at 59:59.99
//   SAT      high while the count is saturated (WRAP=0 builds only)
//
// Modports:
//   master  the controller side: drives the controls, observes the display
//   slave   the counter itself
// -----------------------------------------------------------------------------
interface stopwatch_time_counter_if;
    logic        EN100HZ;
    logic        CLR;
    logic        LAP;
    logic [23:0] DISP;
    logic        LAPHOLD;
    logic        OVF;
    logic        SAT;

    modport master (
        output EN100HZ,
        output CLR,
        output LAP,
        input  DISP,
        input  LAPHOLD,
        input  OVF,
        input  SAT
    );

    modport slave (
        input  EN100HZ,
        input  CLR,
        input  LAP,
        output DISP,
        output LAPHOLD,
        output OVF,
        output SAT
    );
endinterface

// File: rtl/stopwatch_time_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_time_counter
//
// MM:SS.CC stopwatch core. Keeps a six-digit BCD live count advanced by one
// centisecond per EN100HZ tick, a lap snapshot register, and a registered
// display that shows either the live count or the frozen lap value.
//
// Parameters:
//   WRAP  1: roll over from 59:59.99 to 00:00.00
//         0: stick at 59:59.99 and raise SAT until CLR/RST
//
// Ports:
//   CLK   clock, all state updates on the rising edge
//   RST   synchronous, active-high reset (wins over everything)
//   bus   slave side of stopwatch_time_counter_if
//         (EN100HZ, CLR, LAP in; DISP, LAPHOLD, OVF, SAT out)
//
// Priority within a cycle: RST > CLR > {LAP, EN100HZ}. LAP and EN100HZ act
// together; a snapshot taken on LAP captures the count from before the edge.
// -----------------------------------------------------------------------------
module stopwatch_time_counter #(
    parameter bit WRAP = 1'b1
) (
    input  logic                      CLK,
    input  logic                      RST,
    stopwatch_time_counter_if.slave   bus
);

    // Field order matches the display layout: M10 in [23:20], C1 in [3:0].
    typedef struct packed {
        logic [3:0] m10;
        logic [3:0] m1;
        logic [3:0] s10;
        logic [3:0] s1;
        logic [3:0] c10;
        logic [3:0] c1;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    bcd_time_t live_q,    live_d;
    bcd_time_t lap_q,     lap_d;
    bcd_time_t disp_q,    disp_d;
    logic      laphold_q, laphold_d;
    logic      ovf_q,     ovf_d;
    logic      sat_q,     sat_d;

    // -------------------------------------------------------------------------
    // Increment path: live count + 0.01 s, fully resolved in one cycle
    // -------------------------------------------------------------------------
    bcd_time_t live_inc;
    logic      cy_c10;
    logic      cy_s1;
    logic      cy_s10;
    logic      cy_m1;
    logic      cy_m10;
    logic      at_max;

    // Advance one digit if it receives a carry; wraps to 0 past its maximum.
    function automatic logic [3:0] digit_step(
        input logic [3:0] d,
        input logic [3:0] max_val,
        input logic       carry_in
    );
        if (!carry_in) begin
            return d;
        end
        return (d == max_val) ? 4'd0 : d + 4'd1;
    endfunction

    always_comb begin
        // A digit receives a carry only when every lower digit sits at its
        // maximum, so the whole chain is a simple AND ladder.
        cy_c10 = (live_q.c1 == 4'd9);
        cy_s1  = cy_c10 && (live_q.c10 == 4'd9);
        cy_s10 = cy_s1  && (live_q.s1  == 4'd9);
        cy_m1  = cy_s10 && (live_q.s10 == 4'd5);
        cy_m10 = cy_m1  && (live_q.m1  == 4'd9);
        at_max = cy_m10 && (live_q.m10 == 4'd5);

        live_inc.c1  = digit_step(live_q.c1,  4'd9, 1'b1);
        live_inc.c10 = digit_step(live_q.c10, 4'd9, cy_c10);
        live_inc.s1  = digit_step(live_q.s1,  4'd9, cy_s1);
        live_inc.s10 = digit_step(live_q.s10, 4'd5, cy_s10);
        live_inc.m1  = digit_step(live_q.m1,  4'd9, cy_m1);
        // At 59:59.99 this yields 0, so live_inc is already the wrapped value.
        live_inc.m10 = digit_step(live_q.m10, 4'd5, cy_m10);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned; otherwise synthesis infers a latch.
    always_comb begin
        live_d    = live_q;
        lap_d     = lap_q;
        laphold_d = laphold_q;
        ovf_d     = 1'b0;
        sat_d     = sat_q;

        if (bus.CLR) begin
            live_d    = TIME_ZERO;
            lap_d     = TIME_ZERO;
            laphold_d = 1'b0;
            sat_d     = 1'b0;
        end else begin
            // Lap toggle: entering hold snapshots the pre-edge live value.
            if (bus.LAP) begin
                if (!laphold_q) begin
                    lap_d     = live_q;
                    laphold_d = 1'b1;
                end else begin
                    laphold_d = 1'b0;
                end
            end

            // The live count keeps running whatever the lap mode.
            if (bus.EN100HZ) begin
                if (at_max) begin
                    // Only the first overflow pulses; once saturated the
                    // repeated ticks at 59:59.99 stay silent.
                    ovf_d = !sat_q;
                    if (WRAP) begin
                        live_d = live_inc;
                    end else begin
                        sat_d = 1'b1;
                    end
                end else begin
                    live_d = live_inc;
                end
            end
        end

        // Display follows the state being written this edge, so the new
        // value appears in the cycle right after the causing edge.
        disp_d = laphold_d ? lap_d : live_d;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    // NOTE: the design holds only a handful of flops and no memory arrays, so
    // every register is reset; there is no storage that must stay un-reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            live_q    <= TIME_ZERO;
            lap_q     <= TIME_ZERO;
            disp_q    <= TIME_ZERO;
            laphold_q <= 1'b0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            live_q    <= live_d;
            lap_q     <= lap_d;
            disp_q    <= disp_d;
            laphold_q <= laphold_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -------------------------------------------------------------------------
    assign bus.DISP    = disp_q;
    assign bus.LAPHOLD = laphold_q;
    assign bus.OVF     = ovf_q;
    assign bus.SAT     = sat_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_time_counter
//
// Drives a wrapping (WRAP=1) and a saturating (WRAP=0) instance with the same
// stimulus. The reference model keeps the time as a plain centisecond count
// (0 .. 359999) and converts it to BCD with division, independently of the
// digit-wise carry chain in the design.
// -----------------------------------------------------------------------------
module tb_stopwatch_time_counter;

    localparam int MAX_CS = 359999;   // 59:59.99 in centiseconds

    logic CLK;
    logic RST;

    stopwatch_time_counter_if bus_w ();
    stopwatch_time_counter_if bus_s ();

    stopwatch_time_counter #(.WRAP(1'b1)) u_dut_w (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_w)
    );

    stopwatch_time_counter #(.WRAP(1'b0)) u_dut_s (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // -------------------------------------------------------------------------
    // Reference model: index 0 = wrapping instance, index 1 = saturating one
    // -------------------------------------------------------------------------
    int cs     [2];
    int lap_cs [2];
    bit lh     [2];
    bit sat_m  [2];
    bit ovf_m  [2];

    int checks = 0;
    int errors = 0;

    logic [23:0] pre_val;
    bit          ovf_seen;

    function automatic logic [23:0] to_bcd(input int c);
        int m, s, cc;
        m  = c / 6000;
        s  = (c / 100) % 60;
        cc = c % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic logic [23:0] exp_disp(input int i);
        return lh[i] ? to_bcd(lap_cs[i]) : to_bcd(cs[i]);
    endfunction

    task automatic model_step(input bit t, input bit c, input bit l, input bit r);
        for (int i = 0; i < 2; i++) begin
            if (r || c) begin
                cs[i]     = 0;
                lap_cs[i] = 0;
                lh[i]     = 1'b0;
                sat_m[i]  = 1'b0;
                ovf_m[i]  = 1'b0;
            end else begin
                ovf_m[i] = 1'b0;
                if (l) begin
                    if (!lh[i]) begin
                        lap_cs[i] = cs[i];
                        lh[i]     = 1'b1;
                    end else begin
                        lh[i] = 1'b0;
                    end
                end
                if (t) begin
                    if (cs[i] == MAX_CS) begin
                        if (!sat_m[i]) ovf_m[i] = 1'b1;
                        if (i == 0) cs[i] = 0;
                        else        sat_m[i] = 1'b1;
                    end else begin
                        cs[i] = cs[i] + 1;
                    end
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        check("w.disp",    bus_w.DISP,           exp_disp(0));
        check("w.laphold", 24'(bus_w.LAPHOLD),   24'(lh[0]));
        check("w.ovf",     24'(bus_w.OVF),       24'(ovf_m[0]));
        check("w.sat",     24'(bus_w.SAT),       24'(sat_m[0]));
        check("s.disp",    bus_s.DISP,           exp_disp(1));
        check("s.laphold", 24'(bus_s.LAPHOLD),   24'(lh[1]));
        check("s.ovf",     24'(bus_s.OVF),       24'(ovf_m[1]));
        check("s.sat",     24'(bus_s.SAT),       24'(sat_m[1]));
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic drive(input bit t, input bit c, input bit l, input bit r);
        bus_w.EN100HZ = t;  bus_s.EN100HZ = t;
        bus_w.CLR     = c;  bus_s.CLR     = c;
        bus_w.LAP     = l;  bus_s.LAP     = l;
        RST           = r;
    endtask

    // One clock with the given inputs; outputs are sampled 1 time unit later.
    task automatic cycle(input bit t, input bit c, input bit l, input bit r);
        drive(t, c, l, r);
        @(posedge CLK);
        model_step(t, c, l, r);
        #1;
        check_all();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Jump the live count to an arbitrary value by overriding the live
    // register for one idle edge; the design re-captures it as its own state.
    task automatic preload(input int c);
        pre_val = to_bcd(c);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        force u_dut_w.live_q = pre_val;
        force u_dut_s.live_q = pre_val;
        @(posedge CLK);
        model_step(1'b0, 1'b0, 1'b0, 1'b0);
        cs[0] = c;
        cs[1] = c;
        #1;
        release u_dut_w.live_q;
        release u_dut_s.live_q;
        check_all();
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence followed by randomized traffic
    // -------------------------------------------------------------------------
    initial begin
        int pick;
        for (int i = 0; i < 2; i++) begin
            cs[i] = 0; lap_cs[i] = 0; lh[i] = 0; sat_m[i] = 0; ovf_m[i] = 0;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset with random control inputs, which must be ignored
        repeat (3) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b1);
        check("reset.disp", bus_w.DISP, 24'h000000);

        // 100 ticks spaced three cycles apart -> 00:01.00
        ovf_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            ovf_seen = ovf_seen | bus_w.OVF | bus_s.OVF;
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("ticks100.disp", bus_w.DISP, 24'h000100);
        check("ticks100.ovf_seen", 24'(ovf_seen), 24'h0);

        // Minute carry into M10, then full rollover
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        preload(59999);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("carry_m10.disp", bus_w.DISP, 24'h100000);

        preload(MAX_CS);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap.disp", bus_w.DISP, 24'h000000);
        check("wrap.ovf",  24'(bus_w.OVF), 24'h1);
        check("sat.disp",  bus_s.DISP, 24'h595999);
        check("sat.sat",   24'(bus_s.SAT), 24'h1);
        check("sat.ovf",   24'(bus_s.OVF), 24'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap.ovf_drop", 24'(bus_w.OVF), 24'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.ovf_2nd", 24'(bus_s.OVF), 24'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("sat.ovf_3rd",  24'(bus_s.OVF), 24'h0);
        check("sat.disp_hold", bus_s.DISP, 24'h595999);
        check("sat.sat_hold",  24'(bus_s.SAT), 24'h1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("sat.clr_disp", bus_s.DISP, 24'h000000);
        check("sat.clr_sat",  24'(bus_s.SAT), 24'h0);

        // Lap capture coincident with a tick at 00:12.34
        repeat (1234) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("lap.laphold", 24'(bus_w.LAPHOLD), 24'h1);
        check("lap.disp",    bus_w.DISP, 24'h001234);
        repeat (50) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("lap.frozen",  bus_w.DISP, 24'h001234);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("lap.release", bus_w.DISP, 24'h001285);
        check("lap.release_hold", 24'(bus_w.LAPHOLD), 24'h0);

        // LAP held high toggles every cycle
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("lap_held.laphold", 24'(bus_w.LAPHOLD), 24'h1);

        // CLR beats coincident LAP and tick during lap hold
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_lap.disp",    bus_w.DISP, 24'h000000);
        check("clr_lap.laphold", 24'(bus_w.LAPHOLD), 24'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("clr_lap.live", bus_w.DISP, 24'h000001);

        // RST during lap hold at 03:00.00
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        preload(18000);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        check("rst_hold.before", bus_w.DISP, 24'h030000);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_hold.disp",    bus_w.DISP, 24'h000000);
        check("rst_hold.laphold", 24'(bus_w.LAPHOLD), 24'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_hold.first_tick", bus_w.DISP, 24'h000001);

        // Random traffic from random starting points, biased toward carries
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            case ($urandom_range(0, 5))
                0:       pick = 99    - int'($urandom_range(0, 40));
                1:       pick = 5999  - int'($urandom_range(0, 40));
                2:       pick = 59999 - int'($urandom_range(0, 40));
                3:       pick = MAX_CS - int'($urandom_range(0, 40));
                4:       pick = 35999 - int'($urandom_range(0, 40));
                default: pick = int'($urandom_range(0, MAX_CS));
            endcase
            preload(pick);
            for (int j = 0; j < 150; j++) begin
                cycle(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 199) == 0),
                      1'($urandom_range(0, 19) == 0),
                      1'($urandom_range(0, 299) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends on its own
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
